// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - memory-access stage: 64-bit load/store on a word RAM with wait states
module data_mem_stage #(
    parameter int WORD        = 64,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [WORD-1:0] addr,
    input  logic [WORD-1:0] wdata,
    output logic            rsp_valid,
    output logic [WORD-1:0] rdata,
    output logic            rsp_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD-4:0] DEPTH_W  = (WORD-3)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {K_PASS, K_LOAD, K_STORE, K_ERR} kind_t;

    state_t            state_q;
    kind_t             kind_q;
    logic [3:0]        cnt_q;
    logic [WORD-1:0]   addr_q;
    logic              rsp_valid_q;
    logic [WORD-1:0]   rdata_q;
    logic              rsp_err_q;

    logic [WORD-1:0]   mem [DEPTH];

    kind_t             req_kind;
    logic              accept;
    logic [IW-1:0]     req_idx;
    logic [IW-1:0]     rd_idx;
    logic [WORD-1:0]   rd_word;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign rsp_err   = rsp_err_q;

    // Classify the incoming request and select the RAM read index
    always_comb begin
        req_kind = K_PASS;
        if (mem_read && mem_write) begin
            req_kind = K_ERR;
        end else if ((mem_read || mem_write) &&
                     ((addr[2:0] != 3'b000) || (addr[WORD-1:3] >= DEPTH_W))) begin
            req_kind = K_ERR;
        end else if (mem_read) begin
            req_kind = K_LOAD;
        end else if (mem_write) begin
            req_kind = K_STORE;
        end
        accept  = req_valid && (state_q == S_IDLE);
        req_idx = addr[3 +: IW];
        // With zero wait states the load resolves on the accept edge itself,
        // so the live address is used; otherwise the latched one.
        rd_idx  = (state_q == S_IDLE) ? addr[3 +: IW] : addr_q[3 +: IW];
        rd_word = mem[rd_idx];
    end

    function automatic logic [WORD-1:0] resp_data(input kind_t k, input logic [WORD-1:0] a,
                                                  input logic [WORD-1:0] m);
        case (k)
            K_PASS:  resp_data = a;
            K_LOAD:  resp_data = m;
            default: resp_data = '0;
        endcase
    endfunction

    // Stores commit on the accept edge; RAM contents are never reset
    always_ff @(posedge clk) begin
        if (rst_n && accept && (req_kind == K_STORE)) begin
            mem[req_idx] <= wdata;
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kind_q      <= K_PASS;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        kind_q <= req_kind;
                        addr_q <= addr;
                        if ((WAIT_STATES > 0) &&
                            ((req_kind == K_LOAD) || (req_kind == K_STORE))) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= (req_kind == K_ERR);
                            rdata_q     <= resp_data(req_kind, addr, rd_word);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= (kind_q == K_ERR);
                        rdata_q     <= resp_data(kind_q, addr_q, rd_word);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - directed self-checking bench for data_mem_stage
module tb_data_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid0 = 1'b0;
    logic        req_valid1 = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;

    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [63:0] rdata0;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [63:0] rdata1;

    int          cur = 0;
    logic        ready_s, rspv_s, err_s;
    logic [63:0] rdata_s;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] D0 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2 = 64'hA5A5_5A5A_F00D_CAFE;

    always #5 clk = ~clk;

    data_mem_stage #(.WORD(64), .DEPTH(256), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid0), .rdata(rdata0), .rsp_err(rsp_err0)
    );

    data_mem_stage #(.WORD(64), .DEPTH(256), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid1), .rdata(rdata1), .rsp_err(rsp_err1)
    );

    assign ready_s = (cur == 0) ? req_ready0 : req_ready1;
    assign rspv_s  = (cur == 0) ? rsp_valid0 : rsp_valid1;
    assign err_s   = (cur == 0) ? rsp_err0   : rsp_err1;
    assign rdata_s = (cur == 0) ? rdata0     : rdata1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on DUT 'sel'; checks latency, response fields and the single-cycle pulse
    task automatic txn(input int sel, input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] wd, input int exp_lat, input logic [63:0] exp_rd,
                       input logic exp_err, input string tag);
        int lat;
        cur = sel;
        @(negedge clk);
        chk({tag, "_ready_before"}, 64'(ready_s), 64'd1);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        if (sel == 0) req_valid0 = 1'b1;
        else          req_valid1 = 1'b1;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rspv_s && lat < 20);
        chk({tag, "_lat"},   64'(lat),   64'(exp_lat));
        chk({tag, "_rdata"}, rdata_s,    exp_rd);
        chk({tag, "_err"},   64'(err_s), 64'(exp_err));
        @(negedge clk);
        chk({tag, "_pulse_end"}, 64'(rspv_s),  64'd0);
        chk({tag, "_ready_after"}, 64'(ready_s), 64'd1);
    endtask

    // req_valid held high on DUT0 for n requests with current fields; checks accept spacing
    task automatic held(input int n, input int exp_gap, input logic [63:0] exp_rd,
                        input string tag);
        int acc [4];
        int n_acc;
        int n_rsp;
        cur = 0;
        n_acc = 0;
        n_rsp = 0;
        @(negedge clk);
        req_valid0 = 1'b1;
        for (int cyc = 0; cyc < n * exp_gap + 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rsp_valid0) n_rsp++;
            if (req_valid0 && req_ready0) begin
                acc[n_acc] = cyc;
                n_acc++;
                if (n_acc == n) begin
                    @(posedge clk);
                    #1 req_valid0 = 1'b0;
                end
            end
        end
        req_valid0 = 1'b0;
        chk({tag, "_accepts"}, 64'(n_acc), 64'(n));
        chk({tag, "_pulses"},  64'(n_rsp), 64'(n));
        for (int i = 1; i < n; i++) begin
            if (i < n_acc) chk({tag, "_gap"}, 64'(acc[i] - acc[i-1]), 64'(exp_gap));
        end
        chk({tag, "_rdata"}, rdata0, exp_rd);
    endtask

    initial begin
        int pulses;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready0), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid0), 64'd0);
        chk("rst_rdata", rdata0, 64'd0);
        chk("rst_err", 64'(rsp_err0), 64'd0);
        rst_n = 1'b1;

        // 1: store then load, 3-cycle latency each
        txn(0, 1'b0, 1'b1, 64'h10, D0, 3, 64'd0, 1'b0, "t1_store");
        txn(0, 1'b1, 1'b0, 64'h10, 64'd0, 3, D0, 1'b0, "t1_load");

        // 2: pass-through, and back-to-back pass spacing
        txn(0, 1'b0, 1'b0, 64'h7, 64'd0, 1, 64'h7, 1'b0, "t2_pass");
        mem_read = 1'b0; mem_write = 1'b0; addr = 64'hFFFF_0000_0000_0009;
        held(2, 2, 64'hFFFF_0000_0000_0009, "t2_pass_held");

        // 3: rejected requests, no RAM side effects
        txn(0, 1'b1, 1'b0, 64'h0C,  64'd0, 1, 64'd0, 1'b1, "t3_load_misalign");
        txn(0, 1'b0, 1'b1, 64'h14,  D2,    1, 64'd0, 1'b1, "t3_store_misalign");
        txn(0, 1'b1, 1'b0, 64'h800, 64'd0, 1, 64'd0, 1'b1, "t3_load_range");
        txn(0, 1'b1, 1'b1, 64'h10,  D2,    1, 64'd0, 1'b1, "t3_rdwr");
        txn(0, 1'b0, 1'b1, 64'h10_0000_0000_0010, D2, 1, 64'd0, 1'b1, "t3_store_high");
        txn(0, 1'b1, 1'b0, 64'h10,  64'd0, 3, D0,    1'b0, "t3_load_unchanged");

        // Top RAM entry is legal
        txn(0, 1'b0, 1'b1, 64'h7F8, D1,    3, 64'd0, 1'b0, "edge_store_top");
        txn(0, 1'b1, 1'b0, 64'h7F8, 64'd0, 3, D1,    1'b0, "edge_load_top");

        // 4: three held loads, 4 cycles apart
        mem_read = 1'b1; mem_write = 1'b0; addr = 64'h10;
        held(3, 4, D0, "t4_loads");

        // 5: reset during WAIT drops the load
        cur = 0;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; addr = 64'h7F8;
        req_valid0 = 1'b1;
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        @(negedge clk);
        chk("t5_in_wait", 64'(req_ready0), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready", 64'(req_ready0), 64'd1);
        chk("t5_rdata_cleared", rdata0, 64'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid0) pulses++;
            @(negedge clk);
        end
        chk("t5_no_rsp", 64'(pulses), 64'd0);
        txn(0, 1'b1, 1'b0, 64'h10, 64'd0, 3, D0, 1'b0, "t5_store_kept");

        // 6: zero-wait-state build
        txn(1, 1'b0, 1'b1, 64'h0, D1,    1, 64'd0, 1'b0, "t6_store");
        txn(1, 1'b1, 1'b0, 64'h0, 64'd0, 1, D1,    1'b0, "t6_load");
        txn(1, 1'b0, 1'b0, 64'h7, 64'd0, 1, 64'h7, 1'b0, "t6_pass");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
